dbg_probe_sel: RTL and testbench

- Parametrised successor to the core's debug display multiplexer: selects one of NCH probe words for the board display.
- Output is registered; adds auto-scan over channels, snapshot/freeze with cycle timestamp, and an optional compare trigger.
- Sits between the pipelined CPU top (probe sources: PC, instruction, ALU out, control bits, ...) and the 7-segment/LED display driver.

---
 rtl/dbg_pkg.sv | 11 +
 rtl/dbg_scan_ctr.sv | 53 +++++
 rtl/dbg_probe_sel.sv | 97 +++++++++
 tb/tb_dbg_probe_sel.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_pkg.sv
// Shared constants and helpers for the debug probe selector.
package dbg_pkg;

    localparam int unsigned DBG_DW   = 32;
    localparam int unsigned DBG_CNTW = 32;

    function automatic int unsigned clamp_ch(input int unsigned sel, input int unsigned nch);
        return (sel < nch) ? sel : 32'd0;
    endfunction

endpackage

// File: rtl/dbg_scan_ctr.sv
// Channel tracker: follows the manual select, or rotates through channels every SCAN_DIV
// clocks while auto_scan is high.
module dbg_scan_ctr
    import dbg_pkg::*;
#(
    parameter int unsigned NCH      = 8,
    parameter int unsigned SCAN_DIV = 16,
    parameter int unsigned SELW     = $clog2(NCH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            auto_scan,
    input  logic [SELW-1:0] sel,
    output logic [SELW-1:0] cur_ch
);

    localparam int unsigned     DIVW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(SCAN_DIV - 1);
    localparam logic [SELW-1:0] CH_LAST  = SELW'(NCH - 1);

    logic [DIVW-1:0] r_div;
    logic [DIVW-1:0] w_div_d;
    logic [SELW-1:0] r_ch;
    logic [SELW-1:0] w_ch_d;

    // Divider sits at zero in manual mode, so entering auto-scan starts a fresh dwell.
    always_comb begin
        w_div_d = '0;
        w_ch_d  = SELW'(clamp_ch(32'(sel), NCH));
        if (auto_scan) begin
            w_ch_d = r_ch;
            if (r_div == DIV_LAST) begin
                w_div_d = '0;
                w_ch_d  = (r_ch == CH_LAST) ? '0 : r_ch + SELW'(1);
            end else begin
                w_div_d = r_div + DIVW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div <= '0;
            r_ch  <= '0;
        end else begin
            r_div <= w_div_d;
            r_ch  <= w_ch_d;
        end
    end

    assign cur_ch = r_ch;

endmodule

// File: rtl/dbg_probe_sel.sv
// Debug display multiplexer with auto-scan and snapshot/freeze with cycle timestamp.
// Define DBG_PROBE_TRIGGER_EN to add the trig_en/trig_val compare trigger.
module dbg_probe_sel
    import dbg_pkg::*;
#(
    parameter int unsigned NCH      = 8,
    parameter int unsigned DW       = DBG_DW,
    parameter int unsigned SCAN_DIV = 16,
    localparam int unsigned SELW    = $clog2(NCH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NCH*DW-1:0]   probe_in,
    input  logic [SELW-1:0]     sel,
    input  logic                auto_scan,
    input  logic                snap,
    input  logic                clr,
`ifdef DBG_PROBE_TRIGGER_EN
    input  logic                trig_en,
    input  logic [DW-1:0]       trig_val,
`endif
    output logic [DW-1:0]       disdata,
    output logic [SELW-1:0]     cur_ch,
    output logic                frozen,
    output logic [DBG_CNTW-1:0] snap_cycle
);

    logic [SELW-1:0]     w_cur_ch;
    logic [DW-1:0]       w_probes [NCH];
    logic [DW-1:0]       w_probe;
    logic                w_snap_edge;
    logic                w_trig;
    logic                w_capture;
    logic [DW-1:0]       r_disdata;
    logic                r_frozen;
    logic [DBG_CNTW-1:0] r_snap_cycle;
    logic [DBG_CNTW-1:0] r_cycle;
    logic                r_snap_prev;

    dbg_scan_ctr #(
        .NCH      (NCH),
        .SCAN_DIV (SCAN_DIV),
        .SELW     (SELW)
    ) u_scan_ctr (
        .clk       (clk),
        .reset     (reset),
        .auto_scan (auto_scan),
        .sel       (sel),
        .cur_ch    (w_cur_ch)
    );

    for (genvar k = 0; k < NCH; k++) begin : g_probe
        assign w_probes[k] = probe_in[k*DW +: DW];
    end

    assign w_probe     = w_probes[w_cur_ch];
    assign w_snap_edge = snap & ~r_snap_prev;

`ifdef DBG_PROBE_TRIGGER_EN
    assign w_trig = trig_en & (w_probe == trig_val);
`else
    assign w_trig = 1'b0;
`endif

    // clr outranks any capture source in the same cycle.
    assign w_capture = (w_snap_edge | w_trig) & ~r_frozen & ~clr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_disdata    <= '0;
            r_frozen     <= 1'b0;
            r_snap_cycle <= '0;
            r_cycle      <= '0;
            r_snap_prev  <= 1'b0;
        end else begin
            r_cycle     <= r_cycle + DBG_CNTW'(1);
            r_snap_prev <= snap;
            if (!r_frozen) begin
                r_disdata <= w_probe;
            end
            if (clr) begin
                r_frozen <= 1'b0;
            end else if (w_capture) begin
                r_frozen <= 1'b1;
            end
            if (w_capture) begin
                r_snap_cycle <= r_cycle;
            end
        end
    end

    assign disdata    = r_disdata;
    assign cur_ch     = w_cur_ch;
    assign frozen     = r_frozen;
    assign snap_cycle = r_snap_cycle;

endmodule

// File: tb/tb_dbg_probe_sel.sv
// Self-checking bench for dbg_probe_sel: directed scenarios plus randomized traffic against a
// cycle-level behavioural model.
module tb_dbg_probe_sel;

    // Six channels so a 3-bit select can reach out-of-range values.
    localparam int unsigned NCH  = 6;
    localparam int unsigned DW   = 32;
    localparam int unsigned SD   = 4;
    localparam int unsigned SELW = $clog2(NCH);

    logic              clk = 1'b0;
    logic              reset;
    logic [NCH*DW-1:0] probe_in;
    logic [SELW-1:0]   sel;
    logic              auto_scan;
    logic              snap;
    logic              clr;
    logic [DW-1:0]     disdata;
    logic [SELW-1:0]   cur_ch;
    logic              frozen;
    logic [31:0]       snap_cycle;
`ifdef DBG_PROBE_TRIGGER_EN
    logic              trig_en;
    logic [DW-1:0]     trig_val;
`endif

    logic [DW-1:0] probes [NCH];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [31:0]   m_cycle;
    int            m_ch;
    int            m_acnt;
    logic [DW-1:0] m_disp;
    logic          m_frozen;
    logic [31:0]   m_snapc;
    logic          m_prev;

    always #5 clk = ~clk;

    always_comb begin
        probe_in = '0;
        for (int k = 0; k < NCH; k++) probe_in[k*DW +: DW] = probes[k];
    end

    dbg_probe_sel #(
        .NCH      (NCH),
        .DW       (DW),
        .SCAN_DIV (SD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .probe_in   (probe_in),
        .sel        (sel),
        .auto_scan  (auto_scan),
        .snap       (snap),
        .clr        (clr),
`ifdef DBG_PROBE_TRIGGER_EN
        .trig_en    (trig_en),
        .trig_val   (trig_val),
`endif
        .disdata    (disdata),
        .cur_ch     (cur_ch),
        .frozen     (frozen),
        .snap_cycle (snap_cycle)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock: model computes its next state from the current inputs, then all
    // outputs are compared just after the edge.
    task automatic step();
        logic [31:0]   n_cycle;
        logic [31:0]   n_snapc;
        logic [DW-1:0] n_disp;
        logic [DW-1:0] pv;
        int            n_ch;
        int            n_acnt;
        logic          n_frozen;
        logic          n_prev;
        logic          sedge;
        logic          trig;
        logic          cap;
        if (reset) begin
            n_cycle = 0; n_ch = 0; n_acnt = 0; n_disp = 0;
            n_frozen = 0; n_snapc = 0; n_prev = 0;
        end else begin
            pv      = probes[m_ch];
            n_cycle = m_cycle + 32'd1;
            if (auto_scan) begin
                n_acnt = m_acnt + 1;
                n_ch   = (n_acnt % SD == 0) ? (m_ch + 1) % NCH : m_ch;
            end else begin
                n_acnt = 0;
                n_ch   = (int'(sel) < NCH) ? int'(sel) : 0;
            end
            sedge = snap && !m_prev;
            trig  = 1'b0;
`ifdef DBG_PROBE_TRIGGER_EN
            trig  = trig_en && (pv == trig_val);
`endif
            cap      = (sedge || trig) && !m_frozen && !clr;
            n_disp   = m_frozen ? m_disp : pv;
            n_frozen = clr ? 1'b0 : (cap ? 1'b1 : m_frozen);
            n_snapc  = cap ? m_cycle : m_snapc;
            n_prev   = snap;
        end
        @(posedge clk);
        #1;
        m_cycle = n_cycle; m_ch = n_ch; m_acnt = n_acnt; m_disp = n_disp;
        m_frozen = n_frozen; m_snapc = n_snapc; m_prev = n_prev;
        check("m_disdata", 64'(disdata), 64'(m_disp));
        check("m_cur_ch", 64'(cur_ch), 64'(m_ch));
        check("m_frozen", 64'(frozen), 64'(m_frozen));
        check("m_snap_cycle", 64'(snap_cycle), 64'(m_snapc));
    endtask

    task automatic set_default_probes();
        for (int k = 0; k < NCH; k++) probes[k] = 32'h1000 + 32'(k);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        reset = 1'b1; sel = '0; auto_scan = 1'b0; snap = 1'b0; clr = 1'b0;
`ifdef DBG_PROBE_TRIGGER_EN
        trig_en = 1'b0; trig_val = '0;
`endif
        set_default_probes();
        m_cycle = 0; m_ch = 0; m_acnt = 0; m_disp = 0; m_frozen = 0; m_snapc = 0; m_prev = 0;
        #1;
        step();
        step();
        check("rst_disdata", 64'(disdata), 64'h0);
        check("rst_cur_ch", 64'(cur_ch), 64'h0);
        check("rst_frozen", 64'(frozen), 64'h0);
        reset = 1'b0;

        // Manual select latency
        sel = 3'd3;
        step();
        check("sel3_ch", 64'(cur_ch), 64'd3);
        step();
        check("sel3_data", 64'(disdata), 64'h1003);

        // Out-of-range select clamps to channel 0
        sel = 3'd7;
        step();
        step();
        check("oob_ch", 64'(cur_ch), 64'd0);
        check("oob_data", 64'(disdata), 64'h1000);

        // Auto-scan from channel 4, dwell of SD clocks
        sel = 3'd4;
        step();
        step();
        auto_scan = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            check("scan_ch", 64'(cur_ch), 64'((4 + i / SD) % NCH));
            if (i == 5) check("scan_data", 64'(disdata), 64'h1005);
        end

        // Snapshot at counter 100 on channel 2
        auto_scan = 1'b0;
        sel = 3'd2;
        step();
        step();
        guard = 0;
        while (m_cycle != 32'd100 && guard < 200) begin
            step();
            guard++;
        end
        check("reach_cycle100", 64'(m_cycle), 64'd100);
        snap = 1'b1;
        step();
        check("snap_frozen", 64'(frozen), 64'd1);
        check("snap_data", 64'(disdata), 64'h1002);
        check("snap_cycle", 64'(snap_cycle), 64'd100);
        probes[2] = 32'hDEAD;
        step();
        step();
        check("hold_data", 64'(disdata), 64'h1002);
        snap = 1'b0;
        step();
        snap = 1'b1;
        step();
        check("snap2_ignored", 64'(snap_cycle), 64'd100);
        snap = 1'b0;
        clr = 1'b1;
        step();
        check("clr_frozen", 64'(frozen), 64'd0);
        clr = 1'b0;
        step();
        check("clr_live", 64'(disdata), 64'hDEAD);

        // Snap edge and clr together: clr wins
        snap = 1'b1;
        clr = 1'b1;
        step();
        check("both_frozen", 64'(frozen), 64'd0);
        check("both_cycle", 64'(snap_cycle), 64'd100);
        snap = 1'b0;
        clr = 1'b0;
        step();

        // Reset while frozen in auto-scan
        auto_scan = 1'b1;
        snap = 1'b1;
        step();
        check("pre_rst_frozen", 64'(frozen), 64'd1);
        step();
        step();
        reset = 1'b1;
        step();
        check("mid_rst_data", 64'(disdata), 64'h0);
        check("mid_rst_ch", 64'(cur_ch), 64'h0);
        check("mid_rst_frozen", 64'(frozen), 64'h0);
        check("mid_rst_cycle", 64'(snap_cycle), 64'h0);
        reset = 1'b0;
        snap = 1'b0;
        auto_scan = 1'b0;
        set_default_probes();
        step();

`ifdef DBG_PROBE_TRIGGER_EN
        sel = 3'd0;
        step();
        step();
        trig_en = 1'b1;
        trig_val = 32'h1005;
        auto_scan = 1'b1;
        guard = 0;
        while (!m_frozen && guard < 60) begin
            step();
            guard++;
        end
        check("trig_frozen", 64'(frozen), 64'd1);
        check("trig_data", 64'(disdata), 64'h1005);
        trig_en = 1'b0;
        clr = 1'b1;
        step();
        clr = 1'b0;
        auto_scan = 1'b0;
        step();
`endif

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 59) == 0);
            sel   = SELW'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) auto_scan = ~auto_scan;
            snap  = ($urandom_range(0, 2) == 0);
            clr   = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0)
                probes[$urandom_range(0, NCH - 1)] = 32'h1000 + 32'($urandom_range(0, 7));
`ifdef DBG_PROBE_TRIGGER_EN
            trig_en  = ($urandom_range(0, 3) == 0);
            trig_val = 32'h1000 + 32'($urandom_range(0, 7));
`endif
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
